// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - opcode, state and datapath-select encodings for multicycle_control
package mc_ctrl_pkg;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    localparam logic [3:0] S_IF   = 4'd0;
    localparam logic [3:0] S_ID   = 4'd1;
    localparam logic [3:0] S_MADR = 4'd2;
    localparam logic [3:0] S_MRD  = 4'd3;
    localparam logic [3:0] S_MWB  = 4'd4;
    localparam logic [3:0] S_MWR  = 4'd5;
    localparam logic [3:0] S_EXE  = 4'd6;
    localparam logic [3:0] S_RWB  = 4'd7;
    localparam logic [3:0] S_BR   = 4'd8;
    localparam logic [3:0] S_JMP  = 4'd9;
    localparam logic [3:0] S_IEXE = 4'd10;
    localparam logic [3:0] S_IWB  = 4'd11;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_FUNCT = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b100;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that wait on the memory handshake and are covered by the timeout.
    function automatic logic is_wait_state(input logic [3:0] s);
        return (s == S_IF) || (s == S_MRD) || (s == S_MWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - memory wait counter with clear/enable and a timeout flag
module mc_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign timeout = en && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || timeout) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM; CTRL_BNE_EN adds bne via the BR state
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               PCWr,
    output logic               PCWrCond,
    output logic               IorD,
    output logic               IRWr,
    output logic               MemRead,
    output logic               MemWr,
    output logic               MemtoReg,
    output logic               RegWr,
    output logic               RegDst,
    output logic               ALUSrcA,
    output logic               Extop,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               BrNe,
    output logic [3:0]         state,
    output logic               instr_done,
    output logic               illegal_op,
    output logic               mem_err
);

    logic [3:0] state_q;
    logic [3:0] next_state;
    logic       tmr_en;
    logic       tmo;
    logic [2:0] alu_code;

    logic is_r, is_lw, is_sw, is_beq, is_bne, is_j, is_ori, is_addiu;

    assign is_r     = (op == OP_W'(OP_R));
    assign is_lw    = (op == OP_W'(OP_LW));
    assign is_sw    = (op == OP_W'(OP_SW));
    assign is_beq   = (op == OP_W'(OP_BEQ));
    assign is_j     = (op == OP_W'(OP_J));
    assign is_ori   = (op == OP_W'(OP_ORI));
    assign is_addiu = (op == OP_W'(OP_ADDIU));
`ifdef CTRL_BNE_EN
    assign is_bne   = (op == OP_W'(OP_BNE));
`else
    assign is_bne   = 1'b0;
`endif

    assign state  = state_q;
    assign tmr_en = is_wait_state(state_q) && !mem_ready;

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!tmr_en),
        .en      (tmr_en),
        .timeout (tmo)
    );

    always_comb begin
        next_state = S_IF;
        case (state_q)
            S_IF:   next_state = mem_ready ? S_ID : S_IF;
            S_ID: begin
                if (is_lw || is_sw)            next_state = S_MADR;
                else if (is_r)                 next_state = S_EXE;
                else if (is_beq || is_bne)     next_state = S_BR;
                else if (is_j)                 next_state = S_JMP;
                else if (is_ori || is_addiu)   next_state = S_IEXE;
                else                           next_state = S_IF;
            end
            S_MADR: next_state = is_lw ? S_MRD : (is_sw ? S_MWR : S_IF);
            // A timeout drops back to IF, which refetches the instruction.
            S_MRD:  next_state = mem_ready ? S_MWB : (tmo ? S_IF : S_MRD);
            S_MWR:  next_state = (mem_ready || tmo) ? S_IF : S_MWR;
            S_EXE:  next_state = S_RWB;
            S_IEXE: next_state = S_IWB;
            default: next_state = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        PCWr       = 1'b0;
        PCWrCond   = 1'b0;
        IorD       = 1'b0;
        IRWr       = 1'b0;
        MemRead    = 1'b0;
        MemWr      = 1'b0;
        MemtoReg   = 1'b0;
        RegWr      = 1'b0;
        RegDst     = 1'b0;
        ALUSrcA    = 1'b0;
        Extop      = 1'b0;
        ALUSrcB    = SRCB_RT;
        PCSrc      = PCSRC_ALU;
        alu_code   = ALU_ADD;
        BrNe       = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWr    = mem_ready;
                    PCWr    = mem_ready;
                    mem_err = tmo;
                end
                S_ID: begin
                    ALUSrcB    = SRCB_IMM_SH;
                    Extop      = 1'b1;
                    illegal_op = !(is_lw || is_sw || is_r || is_beq || is_bne
                                   || is_j || is_ori || is_addiu);
                end
                S_MADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    Extop   = 1'b1;
                end
                S_MRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    mem_err = tmo;
                end
                S_MWB: begin
                    RegWr      = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MWR: begin
                    MemWr      = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                    mem_err    = tmo;
                end
                S_EXE: begin
                    ALUSrcA  = 1'b1;
                    alu_code = ALU_FUNCT;
                end
                S_RWB: begin
                    RegWr      = 1'b1;
                    RegDst     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BR: begin
                    ALUSrcA    = 1'b1;
                    alu_code   = ALU_SUB;
                    PCWrCond   = 1'b1;
                    PCSrc      = PCSRC_ALUOUT;
                    BrNe       = is_bne;
                    instr_done = 1'b1;
                end
                S_JMP: begin
                    PCWr       = 1'b1;
                    PCSrc      = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
                S_IEXE: begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = SRCB_IMM;
                    alu_code = is_ori ? ALU_OR : ALU_ADD;
                    Extop    = !is_ori;
                end
                S_IWB: begin
                    RegWr      = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ALUop = ALUOP_W'(alu_code);

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

    localparam int TO = 6;

    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] RT    = 6'b000000;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] JJ    = 6'b000010;
    localparam logic [5:0] ORI   = 6'b001101;
    localparam logic [5:0] ADDIU = 6'b001001;
    localparam logic [5:0] ILL   = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;
    logic PCWr, PCWrCond, IorD, IRWr, MemRead, MemWr, MemtoReg, RegWr, RegDst;
    logic ALUSrcA, Extop, BrNe, instr_done, illegal_op, mem_err;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUop;
    logic [3:0] state;
    logic [22:0] ctl;

    int checks   = 0;
    int failures = 0;

    multicycle_control #(
        .OP_W    (6),
        .ALUOP_W (3),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .mem_ready  (mem_ready),
        .PCWr       (PCWr),
        .PCWrCond   (PCWrCond),
        .IorD       (IorD),
        .IRWr       (IRWr),
        .MemRead    (MemRead),
        .MemWr      (MemWr),
        .MemtoReg   (MemtoReg),
        .RegWr      (RegWr),
        .RegDst     (RegDst),
        .ALUSrcA    (ALUSrcA),
        .Extop      (Extop),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUop      (ALUop),
        .BrNe       (BrNe),
        .state      (state),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .mem_err    (mem_err)
    );

    assign ctl = {PCWr, PCWrCond, IorD, IRWr, MemRead, MemWr, MemtoReg, RegWr, RegDst,
                  ALUSrcA, Extop, ALUSrcB, PCSrc, ALUop, BrNe, instr_done, illegal_op, mem_err};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] o, input logic mr);
        op = o;
        mem_ready = mr;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [5:0] o);
        drive(o, 1'b1);
        chk("if_state", state, 0);
        chk("if_irwr", IRWr, 1);
        chk("if_pcwr", PCWr, 1);
        tick();
    endtask

    task automatic decode(input logic [5:0] o);
        drive(o, 1'b1);
        chk("id_state", state, 1);
        chk("id_srcb", ALUSrcB, 2'b11);
        chk("id_illegal", illegal_op, 0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        op = LW;
        mem_ready = 1'b1;
        tick();
        tick();
        drive(LW, 1'b1);
        chk("rst_state", state, 0);
        chk("rst_ctl", ctl, 0);

        // lw, zero wait: 0,1,2,3,4
        rst = 1'b0;
        drive(LW, 1'b1);
        chk("lw_if_memread", MemRead, 1);
        chk("lw_if_srcb", ALUSrcB, 2'b01);
        fetch(LW);
        decode(LW);
        drive(LW, 1'b1);
        chk("lw_madr_state", state, 2);
        chk("lw_madr_srca", ALUSrcA, 1);
        chk("lw_madr_srcb", ALUSrcB, 2'b10);
        tick();
        chk("lw_mrd_state", state, 3);
        chk("lw_mrd_iord", IorD, 1);
        tick();
        chk("lw_mwb_state", state, 4);
        chk("lw_mwb_regwr", RegWr, 1);
        chk("lw_mwb_memtoreg", MemtoReg, 1);
        chk("lw_mwb_done", instr_done, 1);
        tick();
        chk("lw_end_state", state, 0);

        // beq
        fetch(BEQ);
        decode(BEQ);
        drive(BEQ, 1'b1);
        chk("beq_state", state, 8);
        chk("beq_pcwrcond", PCWrCond, 1);
        chk("beq_pcsrc", PCSrc, 2'b01);
        chk("beq_aluop", ALUop, 3'b100);
        chk("beq_brne", BrNe, 0);
        chk("beq_done", instr_done, 1);
        tick();
        chk("beq_end_state", state, 0);

        // ori / addiu
        fetch(ORI);
        decode(ORI);
        drive(ORI, 1'b1);
        chk("ori_state", state, 10);
        chk("ori_extop", Extop, 0);
        chk("ori_aluop", ALUop, 3'b010);
        tick();
        chk("ori_iwb_state", state, 11);
        chk("ori_iwb_regwr", RegWr, 1);
        chk("ori_iwb_regdst", RegDst, 0);
        tick();
        fetch(ADDIU);
        decode(ADDIU);
        drive(ADDIU, 1'b1);
        chk("addiu_extop", Extop, 1);
        chk("addiu_aluop", ALUop, 3'b000);
        tick();
        tick();

        // R-type and jump
        fetch(RT);
        decode(RT);
        drive(RT, 1'b1);
        chk("r_exe_aluop", ALUop, 3'b001);
        tick();
        chk("r_rwb_state", state, 7);
        chk("r_rwb_regdst", RegDst, 1);
        chk("r_rwb_regwr", RegWr, 1);
        tick();
        fetch(JJ);
        decode(JJ);
        drive(JJ, 1'b1);
        chk("j_state", state, 9);
        chk("j_pcwr", PCWr, 1);
        chk("j_pcsrc", PCSrc, 2'b10);
        tick();
        chk("j_end_state", state, 0);

        // sw with 5 wait cycles, ready lands on the timeout count
        fetch(SW);
        decode(SW);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(SW, 1'b0);
            chk("sw_wait_memwr", MemWr, 1);
            chk("sw_wait_done", instr_done, 0);
            chk("sw_wait_err", mem_err, 0);
            tick();
        end
        drive(SW, 1'b1);
        chk("sw_rdy_state", state, 5);
        chk("sw_rdy_memwr", MemWr, 1);
        chk("sw_rdy_done", instr_done, 1);
        chk("sw_rdy_err", mem_err, 0);
        tick();
        chk("sw_end_state", state, 0);

        // lw timing out in MRD
        fetch(LW);
        decode(LW);
        tick();
        for (int i = 0; i < TO - 1; i++) begin
            drive(LW, 1'b0);
            chk("lwto_state", state, 3);
            chk("lwto_early_err", mem_err, 0);
            tick();
        end
        drive(LW, 1'b0);
        chk("lwto_err", mem_err, 1);
        chk("lwto_regwr", RegWr, 0);
        tick();
        chk("lwto_end_state", state, 0);

        // IF times out, then the timer restarts
        for (int i = 0; i < TO - 1; i++) begin
            drive(ILL, 1'b0);
            chk("ifto_early_err", mem_err, 0);
            chk("ifto_irwr", IRWr, 0);
            tick();
        end
        drive(ILL, 1'b0);
        chk("ifto_err", mem_err, 1);
        tick();
        drive(ILL, 1'b0);
        chk("ifto_restart_state", state, 0);
        chk("ifto_restart_err", mem_err, 0);
        tick();

        // IF: ready arriving on the timeout count completes the fetch
        for (int i = 0; i < TO - 2; i++) begin
            drive(ILL, 1'b0);
            tick();
        end
        drive(ILL, 1'b1);
        chk("ifrdy_irwr", IRWr, 1);
        chk("ifrdy_err", mem_err, 0);
        tick();
        drive(ILL, 1'b1);
        chk("ill_state", state, 1);
        chk("ill_pulse", illegal_op, 1);
        tick();
        chk("ill_end_state", state, 0);

        // bne: optional
        fetch(BNE);
        drive(BNE, 1'b1);
`ifdef CTRL_BNE_EN
        chk("bne_illegal", illegal_op, 0);
        tick();
        chk("bne_state", state, 8);
        chk("bne_brne", BrNe, 1);
        chk("bne_pcwrcond", PCWrCond, 1);
        tick();
`else
        chk("bne_illegal", illegal_op, 1);
        tick();
        chk("bne_state", state, 0);
`endif

        // reset in EXE
        fetch(RT);
        decode(RT);
        drive(RT, 1'b1);
        chk("rste_state", state, 6);
        rst = 1'b1;
        #1;
        chk("rste_ctl", ctl, 0);
        tick();
        chk("rste_after_state", state, 0);
        chk("rste_regwr", RegWr, 0);
        rst = 1'b0;
        drive(RT, 1'b1);
        chk("rste_rel_regwr", RegWr, 0);
        chk("rste_rel_irwr", IRWr, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
